branch_resolve_unit: RTL

Parametrised branch resolution stage for the execute pipe: evaluates jump, call and conditional-branch instructions against register operands, computes target and link addresses, and checks the fetch-stage prediction. Holds a small pattern history table of 2-bit counters that it trains on every resolved conditional branch and that fetch reads combinationally. Result is registered behind a valid/ready handshake and feeds writeback (link) and the fetch redirect logic.

---
 rtl/branch_pkg.sv | 32 +++
 rtl/branch_pht.sv | 32 +++
 rtl/branch_resolve_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolution stage: opcode classes, function
// codes and 2-bit predictor counter values.
package branch_pkg;

  localparam logic [4:0] OP_JUMP = 5'b00011;
  localparam logic [4:0] OP_COND = 5'b00100;

  localparam logic [3:0] F_JMP  = 4'b0000;
  localparam logic [3:0] F_CALL = 4'b0001;

  localparam logic [3:0] F_BEQZ = 4'b0000;
  localparam logic [3:0] F_BLTZ = 4'b0001;
  localparam logic [3:0] F_BGTZ = 4'b0010;
  localparam logic [3:0] F_BNEZ = 4'b0011;
  localparam logic [3:0] F_BGEZ = 4'b0100;
  localparam logic [3:0] F_BLEZ = 4'b0101;
  localparam logic [3:0] F_BEQ  = 4'b0110;
  localparam logic [3:0] F_BNE  = 4'b0111;

  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_RESET = CTR_WNT;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_pht.sv
// Pattern history table: array of 2-bit saturating counters with one
// combinational read port and one clocked update port. A read of an entry
// being updated in the same cycle returns the pre-update value.
module branch_pht
  import branch_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] ctr [ENTRIES];

  // Counter storage: reset to weakly-not-taken, otherwise train one entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_RESET;
    end else if (upd_en) begin
      ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
    end
  end

  assign rd_taken = ctr[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: decodes jump/conditional instructions, computes
// direction, target and link address, flags mispredicts, trains the PHT and
// registers the result behind a valid/ready handshake.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PHT_ENTRIES = 64,
  parameter int OFF_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [3:0]        in_func,
  input  logic [DATA_W-1:0] in_reg1,
  input  logic [DATA_W-1:0] in_reg2,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic              in_pred_taken,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic [DATA_W-1:0] out_target,
  output logic              out_link_wr,
  output logic [DATA_W-1:0] out_link_addr,
  output logic              out_mispredict,
  output logic              out_illegal,
  input  logic [DATA_W-1:0] fetch_pc,
  output logic              fetch_pred
);

  localparam int IDX_W = $clog2(PHT_ENTRIES);

  logic              accept;
  logic              legal;
  logic              is_cond;
  logic              taken;
  logic              link;
  logic              neg;
  logic              zero;
  logic              eq;
  logic [DATA_W-1:0] off_sx;
  logic [DATA_W-1:0] pc_next;
  logic [DATA_W-1:0] target;
  logic              mispredict;
  logic              unused_fetch_bits;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign neg  = in_reg1[DATA_W-1];
  assign zero = (in_reg1 == '0);
  assign eq   = (in_reg1 == in_reg2);

  assign off_sx  = DATA_W'($signed(in_offset));
  assign pc_next = in_pc + DATA_W'(4);
  assign target  = taken ? pc_next + (off_sx << 2) : pc_next;
  assign mispredict = legal && (taken != in_pred_taken);

  // Decode opcode/func into legality, direction and link write.
  always_comb begin
    legal   = 1'b0;
    is_cond = 1'b0;
    taken   = 1'b0;
    link    = 1'b0;
    case (in_opcode)
      OP_JUMP: begin
        case (in_func)
          F_JMP:  begin legal = 1'b1; taken = 1'b1; end
          F_CALL: begin legal = 1'b1; taken = 1'b1; link = 1'b1; end
          default: ;
        endcase
      end
      OP_COND: begin
        is_cond = 1'b1;
        legal   = 1'b1;
        case (in_func)
          F_BEQZ:  taken = zero;
          F_BLTZ:  taken = neg;
          F_BGTZ:  taken = !neg && !zero;
          F_BNEZ:  taken = !zero;
          F_BGEZ:  taken = !neg;
          F_BLEZ:  taken = neg || zero;
          F_BEQ:   taken = eq;
          F_BNE:   taken = !eq;
          default: legal = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  // Result register: load on accept, drop valid once drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_target     <= '0;
      out_link_wr    <= 1'b0;
      out_link_addr  <= '0;
      out_mispredict <= 1'b0;
      out_illegal    <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_taken      <= taken;
      out_target     <= target;
      out_link_wr    <= link;
      out_link_addr  <= pc_next;
      out_mispredict <= mispredict;
      out_illegal    <= !legal;
    end else if (out_ready) begin
      out_valid      <= 1'b0;
    end
  end

  branch_pht #(
    .ENTRIES (PHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_pht (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (fetch_pc[IDX_W+1:2]),
    .rd_taken  (fetch_pred),
    .upd_en    (accept && is_cond && legal),
    .upd_idx   (in_pc[IDX_W+1:2]),
    .upd_taken (taken)
  );

  assign unused_fetch_bits = ^{fetch_pc[DATA_W-1:IDX_W+2], fetch_pc[1:0]};

endmodule
